// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory slave.
// Optional feature macro used by the top: MEM_RESPONDER_PROTO_CHECK_EN.
package mem_responder_types;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int WORD_BITS  = 32;
   localparam int LANES      = WORD_BITS / 8;
   localparam int COUNT_BITS = 4;

endpackage

// File: rtl/word_ram.sv
// Single-port, byte-enabled, synchronous word storage with no reset.
// The read returns the word as it was before any write in the same cycle.
module word_ram
   import mem_responder_types::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
)(
   input  logic                 i_clk,
   input  logic                 i_en,
   input  logic                 i_we,
   input  logic [LANES-1:0]     i_be,
   input  logic [AW-1:0]        i_addr,
   input  logic [WORD_BITS-1:0] i_wdata,
   output logic [WORD_BITS-1:0] o_rdata
);

   logic [WORD_BITS-1:0] r_mem [DEPTH_WORDS];

   // Enabled access: write the selected lanes and register the old word for reads.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int lane = 0; lane < LANES; lane++) begin
               if (i_be[lane]) begin
                  r_mem[i_addr][8*lane +: 8] <= i_wdata[8*lane +: 8];
               end
            end
         end
         o_rdata <= r_mem[i_addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: captures one request in IDLE, waits in BUSY,
// then pulses mem_resp for one cycle in RESP. Storage lives in word_ram.
// Optional macro MEM_RESPONDER_PROTO_CHECK_EN adds the sticky proto_err output,
// flagging an initiator that drops or alters its request while we are busy.
module mem_responder
   import mem_responder_types::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 3
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_address,
   input  logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_resp,
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
   output logic        proto_err,
`endif
   output logic        addr_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [COUNT_BITS-1:0] COUNT_INIT = COUNT_BITS'(LATENCY - 1);

   if (LATENCY < 1 || LATENCY > 15) begin : g_badLatency
      $fatal(1, "mem_responder: LATENCY must be in 1..15");
   end

   if (DEPTH_WORDS < 16 || DEPTH_WORDS > 4096 ||
       (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_badDepth
      $fatal(1, "mem_responder: DEPTH_WORDS must be a power of two in 16..4096");
   end

   state_t                r_state;
   logic [COUNT_BITS-1:0] r_count;
   logic                  r_resp;
   logic                  r_rdataOk;
   logic                  r_addrErr;

   logic                  r_capWrite;
   logic                  r_capErr;
   logic [AW-1:0]         r_capIdx;
   logic [LANES-1:0]      r_capBe;
   logic [WORD_BITS-1:0]  r_capWdata;

   logic                  w_req;
   logic [AW-1:0]         w_liveIdx;
   logic                  w_liveErr;
   logic                  w_inIdle;
   logic                  w_enterResp;
   logic                  w_opWrite;
   logic                  w_opErr;
   logic [AW-1:0]         w_opIdx;
   logic [LANES-1:0]      w_opBe;
   logic [WORD_BITS-1:0]  w_opWdata;
   logic                  w_readOk;
   logic                  w_ramEn;
   logic                  w_ramWe;
   logic [WORD_BITS-1:0]  w_ramRdata;
   logic                  w_unused;

   // Byte offset within the word carries no meaning here.
   assign w_unused  = &{1'b0, mem_address[1:0]};

   assign w_req     = mem_read | mem_write;
   assign w_liveIdx = mem_address[AW+1:2];
   assign w_liveErr = |mem_address[31:AW+2];
   assign w_inIdle  = (r_state == IDLE);

   // With LATENCY=1 the access happens on the capture edge itself, so the
   // storage must see the live request rather than the not-yet-captured copy.
   assign w_enterResp = (w_inIdle && w_req && (LATENCY == 1)) ||
                        ((r_state == BUSY) && (r_count == COUNT_BITS'(1)));
   assign w_opWrite   = w_inIdle ? mem_write       : r_capWrite;
   assign w_opErr     = w_inIdle ? w_liveErr       : r_capErr;
   assign w_opIdx     = w_inIdle ? w_liveIdx       : r_capIdx;
   assign w_opBe      = w_inIdle ? mem_byte_enable : r_capBe;
   assign w_opWdata   = w_inIdle ? mem_wdata       : r_capWdata;
   assign w_readOk    = ~w_opWrite & ~w_opErr;

   // Reset on the commit edge must abort the write, so it gates the enable.
   assign w_ramEn = w_enterResp & ~rst;
   assign w_ramWe = w_opWrite & ~w_opErr;

   word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .i_clk   (clk),
      .i_en    (w_ramEn),
      .i_we    (w_ramWe),
      .i_be    (w_opBe),
      .i_addr  (w_opIdx),
      .i_wdata (w_opWdata),
      .o_rdata (w_ramRdata)
   );

   // Latch the request attributes when IDLE accepts it (write wins over read).
   always_ff @(posedge clk) begin
      if (w_inIdle && w_req) begin
         r_capWrite <= mem_write;
         r_capErr   <= w_liveErr;
         r_capIdx   <= w_liveIdx;
         r_capBe    <= mem_byte_enable;
         r_capWdata <= mem_wdata;
      end
   end

   // Control FSM: IDLE accepts, BUSY counts down, RESP emits the one-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_resp    <= 1'b0;
         r_rdataOk <= 1'b0;
         r_addrErr <= 1'b0;
      end else begin
         r_resp    <= 1'b0;
         r_rdataOk <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  if (LATENCY == 1) begin
                     r_state   <= RESP;
                     r_resp    <= 1'b1;
                     r_rdataOk <= w_readOk;
                     r_addrErr <= r_addrErr | w_opErr;
                  end else begin
                     r_state <= BUSY;
                     r_count <= COUNT_INIT;
                  end
               end
            end
            BUSY: begin
               if (r_count == COUNT_BITS'(1)) begin
                  r_state   <= RESP;
                  r_count   <= '0;
                  r_resp    <= 1'b1;
                  r_rdataOk <= w_readOk;
                  r_addrErr <= r_addrErr | w_opErr;
               end else begin
                  r_count <= r_count - COUNT_BITS'(1);
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign mem_resp  = r_resp;
   assign mem_rdata = r_rdataOk ? w_ramRdata : '0;
   assign addr_err  = r_addrErr;

`ifdef MEM_RESPONDER_PROTO_CHECK_EN
   logic [31:0] r_capAddr;
   logic        r_protoErr;

   // Full address kept only for comparing against the held request.
   always_ff @(posedge clk) begin
      if (w_inIdle && w_req) begin
         r_capAddr <= mem_address;
      end
   end

   // Sticky flag when the initiator drops or alters its request while BUSY.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_protoErr <= 1'b0;
      end else if ((r_state == BUSY) &&
                   (!w_req || (mem_write != r_capWrite) || (mem_address != r_capAddr))) begin
         r_protoErr <= 1'b1;
      end
   end

   assign proto_err = r_protoErr;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with LATENCY=3 and one
// with LATENCY=1, both DEPTH_WORDS=256. A transaction-level model watches the
// request bus and predicts every output cycle by cycle.
module tb_mem_responder;

   localparam int DEPTH = 256;

   logic        clk;
   logic        rst       [2];
   logic        memRead   [2];
   logic        memWrite  [2];
   logic [31:0] memAddr   [2];
   logic [3:0]  memBe     [2];
   logic [31:0] memWdata  [2];
   logic [31:0] memRdata  [2];
   logic        memResp   [2];
   logic        addrErr   [2];
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
   logic        protoErr  [2];
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) dut3 (
      .clk             (clk),
      .rst             (rst[0]),
      .mem_read        (memRead[0]),
      .mem_write       (memWrite[0]),
      .mem_address     (memAddr[0]),
      .mem_byte_enable (memBe[0]),
      .mem_wdata       (memWdata[0]),
      .mem_rdata       (memRdata[0]),
      .mem_resp        (memResp[0]),
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
      .proto_err       (protoErr[0]),
`endif
      .addr_err        (addrErr[0])
   );

   mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .clk             (clk),
      .rst             (rst[1]),
      .mem_read        (memRead[1]),
      .mem_write       (memWrite[1]),
      .mem_address     (memAddr[1]),
      .mem_byte_enable (memBe[1]),
      .mem_wdata       (memWdata[1]),
      .mem_rdata       (memRdata[1]),
      .mem_resp        (memResp[1]),
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
      .proto_err       (protoErr[1]),
`endif
      .addr_err        (addrErr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int latOf(input int i);
      return (i == 0) ? 3 : 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   logic [31:0] memModel   [2][DEPTH];
   bit          mValid     [2];
   bit          pendValid  [2];
   int          capCycle   [2];
   int          pendCycle  [2];
   int          lastResp   [2];
   bit          pendWrite  [2];
   bit          pendErr    [2];
   logic [31:0] pendAddr   [2];
   int          pendIdx    [2];
   logic [3:0]  pendBe     [2];
   logic [31:0] pendWdata  [2];
   bit          errSticky  [2];
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
   bit          protoSticky[2];
`endif

   initial begin
      for (int i = 0; i < 2; i++) begin
         mValid[i]    = 1'b0;
         pendValid[i] = 1'b0;
         errSticky[i] = 1'b0;
         lastResp[i]  = -1;
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
         protoSticky[i] = 1'b0;
`endif
      end
   end

   // Compare outputs against the model mid-cycle, then advance the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit          expResp;
         logic [31:0] expData;
         expResp = pendValid[i] && (cyc == pendCycle[i]);
         expData = 32'h0;
         if (expResp && pendErr[i]) errSticky[i] = 1'b1;
         if (expResp && !pendWrite[i] && !pendErr[i]) expData = memModel[i][pendIdx[i]];
         if (mValid[i]) begin
            checkOutput($sformatf("resp%0d", i), {31'h0, memResp[i]}, {31'h0, expResp});
            checkOutput($sformatf("rdata%0d", i), memRdata[i], expData);
            checkOutput($sformatf("addrErr%0d", i), {31'h0, addrErr[i]}, {31'h0, errSticky[i]});
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
            checkOutput($sformatf("protoErr%0d", i), {31'h0, protoErr[i]}, {31'h0, protoSticky[i]});
`endif
         end
         if (rst[i]) begin
            mValid[i]    = 1'b1;
            pendValid[i] = 1'b0;
            errSticky[i] = 1'b0;
            lastResp[i]  = cyc;
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
            protoSticky[i] = 1'b0;
`endif
         end else if (mValid[i]) begin
            if (expResp) begin
               if (pendWrite[i] && !pendErr[i]) begin
                  for (int b = 0; b < 4; b++) begin
                     if (pendBe[i][b]) memModel[i][pendIdx[i]][8*b +: 8] = pendWdata[i][8*b +: 8];
                  end
               end
               pendValid[i] = 1'b0;
               lastResp[i]  = cyc;
            end else if (pendValid[i]) begin
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
               if (cyc > capCycle[i] &&
                   (!(memRead[i] || memWrite[i]) || memWrite[i] != pendWrite[i] ||
                    memAddr[i] != pendAddr[i]))
                  protoSticky[i] = 1'b1;
`endif
            end else if (cyc > lastResp[i] && (memRead[i] || memWrite[i])) begin
               pendValid[i] = 1'b1;
               capCycle[i]  = cyc;
               pendCycle[i] = cyc + latOf(i);
               pendWrite[i] = memWrite[i];
               pendAddr[i]  = memAddr[i];
               pendErr[i]   = (memAddr[i] >= 32'(DEPTH * 4));
               pendIdx[i]   = int'((memAddr[i] >> 2) % DEPTH);
               pendBe[i]    = memBe[i];
               pendWdata[i] = memWdata[i];
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic applyReset(input int i, input int n);
      rst[i]      = 1'b1;
      memRead[i]  = 1'b0;
      memWrite[i] = 1'b0;
      repeat (n) nextCycle();
      rst[i] = 1'b0;
   endtask

   task automatic applyStimulus(input int i, input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wd, input bit dropEarly,
                                input bit checkData, input logic [31:0] expData, input string name);
      int tReq;
      int waited;
      bit seen;
      memRead[i]  = rd;
      memWrite[i] = wr;
      memAddr[i]  = addr;
      memBe[i]    = be;
      memWdata[i] = wd;
      tReq   = cyc;
      waited = 0;
      seen   = 1'b0;
      if (dropEarly) begin
         nextCycle();
         memRead[i]  = 1'b0;
         memWrite[i] = 1'b0;
      end
      while (!seen && waited < 40) begin
         @(negedge clk);
         if (memResp[i] === 1'b1) seen = 1'b1;
         else waited++;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: got no mem_resp, want one within %0d cycles", name, latOf(i));
      end else begin
         checkOutput({name, " latency"}, 32'(cyc - tReq), 32'(latOf(i)));
         if (checkData) checkOutput({name, " rdata"}, memRdata[i], expData);
      end
      nextCycle();
      memRead[i]  = 1'b0;
      memWrite[i] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; memRead[i] = 1'b0; memWrite[i] = 1'b0;
         memAddr[i] = '0; memBe[i] = '0; memWdata[i] = '0;
      end
      nextCycle();
      applyReset(0, 3);
      applyReset(1, 1);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("reset resp%0d", i), {31'h0, memResp[i]}, 32'h0);
         checkOutput($sformatf("reset rdata%0d", i), memRdata[i], 32'h0);
         checkOutput($sformatf("reset addrErr%0d", i), {31'h0, addrErr[i]}, 32'h0);
      end

      // LATENCY=3 basic write/read, partial lanes, empty mask, write-wins, low bits ignored
      applyStimulus(0, 0, 1, 32'h40, 4'hF, 32'hDEADBEEF, 0, 1, 32'h0, "wr40");
      applyStimulus(0, 1, 0, 32'h40, 4'h0, 32'h0, 0, 1, 32'hDEADBEEF, "rd40");
      applyStimulus(0, 0, 1, 32'h10, 4'hF, 32'h11223344, 0, 0, 32'h0, "wr10");
      applyStimulus(0, 0, 1, 32'h10, 4'h5, 32'hAABBCCDD, 0, 0, 32'h0, "wr10be5");
      applyStimulus(0, 1, 0, 32'h10, 4'h0, 32'h0, 0, 1, 32'h11BB33DD, "rd10");
      applyStimulus(0, 0, 1, 32'h40, 4'h0, 32'h01234567, 0, 0, 32'h0, "wr40be0");
      applyStimulus(0, 1, 0, 32'h40, 4'h0, 32'h0, 0, 1, 32'hDEADBEEF, "rd40after");
      applyStimulus(0, 1, 1, 32'h80, 4'hF, 32'h0F0F0F0F, 0, 1, 32'h0, "both80");
      applyStimulus(0, 1, 0, 32'h83, 4'h0, 32'h0, 0, 1, 32'h0F0F0F0F, "rd83");

      // Out-of-range write aliasing word 0 must be dropped
      applyStimulus(0, 0, 1, 32'h0, 4'hF, 32'hCAFEF00D, 0, 0, 32'h0, "wr0");
      applyStimulus(0, 0, 1, 32'h400, 4'hF, 32'h12345678, 0, 0, 32'h0, "wr400");
      checkOutput("addrErr after wr400", {31'h0, addrErr[0]}, 32'h1);
      applyReset(0, 1);
      checkOutput("addrErr cleared", {31'h0, addrErr[0]}, 32'h0);
      applyStimulus(0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'hCAFEF00D, "rd0");
      applyStimulus(0, 1, 0, 32'h0001_0000, 4'h0, 32'h0, 0, 1, 32'h0, "rdFar");
      checkOutput("addrErr set", {31'h0, addrErr[0]}, 32'h1);
      repeat (5) nextCycle();
      checkOutput("addrErr sticky", {31'h0, addrErr[0]}, 32'h1);

      // Reset landing on the commit edge aborts the write
      memWrite[0] = 1'b1; memAddr[0] = 32'h40; memBe[0] = 4'hF; memWdata[0] = 32'h55555555;
      nextCycle();
      nextCycle();
      rst[0] = 1'b1; memWrite[0] = 1'b0;
      nextCycle();
      rst[0] = 1'b0;
      @(negedge clk);
      checkOutput("abort noResp", {31'h0, memResp[0]}, 32'h0);
      nextCycle();
      applyStimulus(0, 1, 0, 32'h40, 4'h0, 32'h0, 0, 1, 32'hDEADBEEF, "rd40postAbort");

      // Request dropped mid-BUSY still completes on time
      applyStimulus(0, 1, 0, 32'h10, 4'h0, 32'h0, 1, 1, 32'h11BB33DD, "rd10drop");
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
      checkOutput("protoErr after drop", {31'h0, protoErr[0]}, 32'h1);
`endif

      // LATENCY=1: back-to-back accesses, one response every second cycle
      applyStimulus(1, 0, 1, 32'h20, 4'hF, 32'hA5A5A5A5, 0, 0, 32'h0, "l1wr20");
      applyStimulus(1, 0, 1, 32'h24, 4'hF, 32'h5A5A5A5A, 0, 0, 32'h0, "l1wr24");
      applyStimulus(1, 1, 0, 32'h20, 4'h0, 32'h0, 0, 1, 32'hA5A5A5A5, "l1rd20");
      applyStimulus(1, 1, 0, 32'h24, 4'h0, 32'h0, 0, 1, 32'h5A5A5A5A, "l1rd24");
      applyStimulus(1, 1, 0, 32'h20, 4'h0, 32'h0, 0, 1, 32'hA5A5A5A5, "l1rd20b");
      applyStimulus(1, 0, 1, 32'h20, 4'h6, 32'h00FFFF00, 0, 0, 32'h0, "l1wr20be6");
      applyStimulus(1, 1, 0, 32'h20, 4'h0, 32'h0, 0, 1, 32'hA5FFFFA5, "l1rd20c");

      repeat (3) nextCycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion, want finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
